// File: rtl/fast_spi_burst_sched_pkg.sv
// Shared types and defaults for the fast SPI burst scheduler.
package fast_spi_pkg;

  typedef enum logic [1:0] {IDLE, HDR, DATA, WAIT_ACK} state_t;

  localparam logic [7:0] ACK_CMD_DEF = 8'hA5;
  localparam logic [3:0] HDR_NIB_DEF = 4'hB;

  // Modulo increment of a requester index.
  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] last);
    return (v == last) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/fast_spi_burst_sched_if.sv
// Source streams, TX stream to the SPI FIFO and the RX ack path of the burst scheduler.
interface fast_spi_burst_sched_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0][7:0]  s_axis_tdata;
  logic [NREQ-1:0]       s_axis_tvalid;
  logic [NREQ-1:0]       s_axis_tready;
  logic [7:0]            m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [7:0]            rx_tdata;
  logic                  rx_tvalid;

  modport master (
    input  req, s_axis_tdata, s_axis_tvalid, m_axis_tready, rx_tdata, rx_tvalid,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  modport slave (
    output req, s_axis_tdata, s_axis_tvalid, m_axis_tready, rx_tdata, rx_tvalid,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/fast_spi_burst_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [3:0]      ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [3:0]      gnt_idx,
  output logic            gnt_any
);

  always_comb begin
    int j;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_any && req[j]) begin
        gnt_any   = 1'b1;
        gnt_oh[j] = 1'b1;
        gnt_idx   = 4'(j);
      end
    end
  end

endmodule

// File: rtl/fast_spi_burst_sched.sv
// Round-robin burst scheduler: header + BURST_LEN payload bytes per grant, then
// irq until the SPI master acks over RX (or the ack timeout expires).
module fast_spi_burst_sched
  import fast_spi_pkg::*;
#(
  parameter int          NREQ        = 4,
  parameter int          BURST_LEN   = 256,
  parameter logic [3:0]  HDR_NIB     = HDR_NIB_DEF,
  parameter logic [7:0]  ACK_CMD     = ACK_CMD_DEF,
  parameter int unsigned ACK_TIMEOUT = 2**20
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    enable,
  fast_spi_burst_sched_if.master  bus,
  output logic                    irq,
  output logic [3:0]              grant_id,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [15:0]             bursts_done
);

  localparam logic [3:0]  LAST_ID   = 4'(NREQ - 1);
  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic [3:0]        rr_ptr;
  logic [NREQ-1:0]   gnt_q;
  logic [15:0]       beat_cnt;
  logic [31:0]       to_cnt;

  logic [NREQ-1:0]   arb_oh;
  logic [3:0]        arb_idx;
  logic              arb_any;

  logic              grant, beat, last_beat, ack_hit, to_hit;
  logic              m_tvalid;
  logic [7:0]        m_tdata;
  logic [NREQ-1:0]   s_tready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (bus.req),
    .ptr     (rr_ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign ack_hit = bus.rx_tvalid && (bus.rx_tdata == ACK_CMD);
  assign to_hit  = (ACK_TIMEOUT != 0) && (to_cnt == ACK_TIMEOUT - 1);
  assign busy    = (state_q != IDLE);

  assign bus.m_axis_tvalid = m_tvalid;
  assign bus.m_axis_tdata  = m_tdata;
  assign bus.s_axis_tready = s_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    m_tvalid  = 1'b0;
    m_tdata   = '0;
    s_tready  = '0;
    grant     = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      IDLE: begin
        grant = enable && arb_any;
        if (grant) state_d = HDR;
      end
      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = {HDR_NIB, grant_id};
        if (bus.m_axis_tready) state_d = DATA;
      end
      DATA: begin
        // gnt_q is one-hot, so OR-reduction acts as the source mux
        for (int i = 0; i < NREQ; i++) begin
          if (gnt_q[i]) begin
            m_tvalid    = m_tvalid | bus.s_axis_tvalid[i];
            m_tdata     = m_tdata  | bus.s_axis_tdata[i];
            s_tready[i] = bus.m_axis_tready;
          end
        end
        beat      = m_tvalid && bus.m_axis_tready;
        last_beat = beat && (beat_cnt == LAST_BEAT);
        if (last_beat) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_hit || to_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rr_ptr      <= '0;
      grant_id    <= '0;
      gnt_q       <= '0;
      beat_cnt    <= '0;
      to_cnt      <= '0;
      irq         <= 1'b0;
      timeout_err <= 1'b0;
      bursts_done <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            grant_id <= arb_idx;
            gnt_q    <= arb_oh;
          end
        end
        HDR: begin
          beat_cnt <= '0;
          to_cnt   <= '0;
        end
        DATA: begin
          if (beat)      beat_cnt <= beat_cnt + 16'd1;
          if (last_beat) irq      <= 1'b1;
        end
        WAIT_ACK: begin
          // A real ack wins over a timeout landing on the same cycle
          if (ack_hit) begin
            irq         <= 1'b0;
            bursts_done <= bursts_done + 16'd1;
            rr_ptr      <= wrap_inc(grant_id, LAST_ID);
          end else if (to_hit) begin
            irq         <= 1'b0;
            timeout_err <= 1'b1;
            rr_ptr      <= wrap_inc(grant_id, LAST_ID);
          end else begin
            to_cnt      <= to_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fast_spi_burst_sched.sv
// Directed bench for fast_spi_burst_sched (NREQ=4, BURST_LEN=4, ACK_TIMEOUT=16).
module tb_fast_spi_burst_sched;

  localparam int NREQ = 4;
  localparam int BL   = 4;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic        enable = 1'b0;
  logic        irq, busy, timeout_err;
  logic [3:0]  grant_id;
  logic [15:0] bursts_done;

  fast_spi_burst_sched_if #(.NREQ(NREQ)) bus ();

  fast_spi_burst_sched #(
    .NREQ(NREQ), .BURST_LEN(BL), .HDR_NIB(4'hB), .ACK_CMD(8'hA5), .ACK_TIMEOUT(16)
  ) dut (
    .aclk(aclk), .areset(areset), .enable(enable), .bus(bus),
    .irq(irq), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err), .bursts_done(bursts_done)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]      base [NREQ];
  logic [7:0]      src_cnt [NREQ];
  logic [7:0]      nxt [NREQ];
  logic [NREQ-1:0] src_en = '0;
  logic            tog_mode = 1'b0;
  logic            gap_mode = 1'b0;
  logic [7:0]      cyc = '0;
  logic [7:0]      cap [$];

  // Source model: each source emits base+count, advancing on its own handshake
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.s_axis_tdata[i]  = base[i] + src_cnt[i];
      bus.s_axis_tvalid[i] = src_en[i] & ~(gap_mode & ((cyc % 8'd3) == 8'd2));
    end
  end
  assign bus.m_axis_tready = tog_mode ? cyc[0] : 1'b1;

  always @(posedge aclk) begin
    cyc <= cyc + 8'd1;
    for (int i = 0; i < NREQ; i++)
      if (bus.s_axis_tvalid[i] && bus.s_axis_tready[i]) src_cnt[i] <= src_cnt[i] + 8'd1;
    if (bus.m_axis_tvalid && bus.m_axis_tready) cap.push_back(bus.m_axis_tdata);
  end

  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (irq !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(irq), 32'd1);
  endtask

  task automatic wait_cap(input string tag, input int sz);
    int n = 0;
    while (cap.size() < sz && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(cap.size() >= sz), 32'd1);
  endtask

  task automatic send_ack();
    cap.delete();
    bus.rx_tdata  = 8'hA5;
    bus.rx_tvalid = 1'b1;
    step();
    bus.rx_tvalid = 1'b0;
    bus.rx_tdata  = 8'h00;
  endtask

  // Expect header {B,g} then the next BL bytes of source g
  task automatic chk_burst(input string tag, input int g);
    chk({tag, "_len"}, 32'(cap.size()), 32'(BL + 1));
    if (cap.size() >= 1) chk({tag, "_hdr"}, 32'(cap[0]), 32'({4'hB, 4'(g)}));
    for (int k = 1; k < cap.size() && k <= BL; k++)
      chk($sformatf("%s_b%0d", tag, k), 32'(cap[k]), 32'(8'(base[g] + nxt[g] + 8'(k - 1))));
    nxt[g] = nxt[g] + 8'(BL);
  endtask

  initial begin
    base = '{8'hC0, 8'h40, 8'h10, 8'h70};
    for (int i = 0; i < NREQ; i++) begin
      src_cnt[i] = '0;
      nxt[i]     = '0;
    end
    bus.req = '0;
    bus.rx_tdata = '0;
    bus.rx_tvalid = 1'b0;
    #1 areset = 1'b1;
    step();
    step();

    // Reset state
    chk("rst_irq", 32'(irq), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    chk("rst_done", 32'(bursts_done), 0);
    chk("rst_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("rst_tready", 32'(bus.s_axis_tready), 0);

    // Single burst from source 2, req dropped after grant
    areset = 1'b0;
    src_en = 4'b1111;
    enable = 1'b1;
    bus.req = 4'b0100;
    step();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_hdr_valid", 32'(bus.m_axis_tvalid), 1);
    chk("t1_hdr_data", 32'(bus.m_axis_tdata), 32'hB2);
    chk("t1_hdr_tready", 32'(bus.s_axis_tready), 0);
    bus.req = '0;
    wait_irq("t1_irq");
    chk("t1_gid", 32'(grant_id), 2);
    chk_burst("t1", 2);
    chk("t1_wait_tvalid", 32'(bus.m_axis_tvalid), 0);
    bus.rx_tdata = 8'h5A;
    bus.rx_tvalid = 1'b1;
    step();
    bus.rx_tvalid = 1'b0;
    chk("t1_nonack_irq", 32'(irq), 1);
    chk("t1_nonack_busy", 32'(busy), 1);
    send_ack();
    chk("t1_ack_irq", 32'(irq), 0);
    chk("t1_ack_done", 32'(bursts_done), 1);
    chk("t1_ack_busy", 32'(busy), 0);

    // Round robin over all four requesters after a fresh reset
    areset = 1'b1;
    #1;
    areset = 1'b0;
    chk("t2_rst_done", 32'(bursts_done), 0);
    bus.req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      wait_irq($sformatf("t2_irq%0d", b));
      chk($sformatf("t2_gid%0d", b), 32'(grant_id), 32'(b % 4));
      chk_burst($sformatf("t2_%0d", b), b % 4);
      if (b == 4) bus.req = '0;
      send_ack();
    end
    chk("t2_done", 32'(bursts_done), 5);
    chk("t2_busy", 32'(busy), 0);

    // Downstream backpressure toggling plus source valid gaps
    tog_mode = 1'b1;
    gap_mode = 1'b1;
    bus.req = 4'b0001;
    step();
    bus.req = '0;
    chk("t3_busy", 32'(busy), 1);
    wait_irq("t3_irq");
    chk_burst("t3", 0);
    send_ack();
    chk("t3_done", 32'(bursts_done), 6);
    tog_mode = 1'b0;
    gap_mode = 1'b0;

    // No ack: forced release after 16 cycles in WAIT_ACK
    bus.req = 4'b0001;
    step();
    bus.req = '0;
    wait_irq("t4_irq");
    begin
      int n = 0;
      while (irq === 1'b1 && n < 100) begin
        n++;
        step();
      end
      chk("t4_irq_cycles", 32'(n), 16);
    end
    chk("t4_terr", 32'(timeout_err), 1);
    chk("t4_done", 32'(bursts_done), 6);
    chk("t4_busy", 32'(busy), 0);
    chk_burst("t4", 0);
    cap.delete();

    // enable dropped mid-DATA; ack during DATA is ignored
    bus.req = 4'b0001;
    step();
    wait_cap("t5_in_data", 2);
    enable = 1'b0;
    bus.rx_tdata = 8'hA5;
    bus.rx_tvalid = 1'b1;
    step();
    bus.rx_tvalid = 1'b0;
    chk("t5_early_ack_busy", 32'(busy), 1);
    wait_irq("t5_irq");
    chk_burst("t5", 0);
    chk("t5_done_pre", 32'(bursts_done), 6);
    send_ack();
    chk("t5_done", 32'(bursts_done), 7);
    repeat (10) step();
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_cap", 32'(cap.size()), 0);
    chk("t5_idle_tvalid", 32'(bus.m_axis_tvalid), 0);

    // Async reset in DATA, then arbitration restarts from source 0
    enable = 1'b1;
    step();
    chk("t6_busy", 32'(busy), 1);
    wait_cap("t6_in_data", 3);
    areset = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_irq", 32'(irq), 0);
    chk("t6_rst_tvalid", 32'(bus.m_axis_tvalid), 0);
    chk("t6_rst_tready", 32'(bus.s_axis_tready), 0);
    chk("t6_rst_terr", 32'(timeout_err), 0);
    chk("t6_rst_done", 32'(bursts_done), 0);
    step();
    areset = 1'b0;
    cap.delete();
    bus.req = 4'b1111;
    step();
    chk("t6_regrant_busy", 32'(busy), 1);
    chk("t6_regrant_gid", 32'(grant_id), 0);
    chk("t6_regrant_hdr", 32'(bus.m_axis_tdata), 32'hB0);
    bus.req = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
